ysyx_201979054_burst_tracker: RTL and testbench
===============================================

// Module: ysyx_201979054_burst_tracker
// PURPOSE
//   Programmable-length beat tracker for AXI4-Lite/AXI4 burst transfers.
//   Latches a per-burst length at start and counts handshaken beats.
//   Flags the final beat and pulses done after the last beat completes.
//   Detects stalled bursts with a watchdog and parks in an error state until cleared.
//   Sits beside the bus-master FSM in the memory interface.
// PARAMETERS
//   CNT_W     8    width of i_len/o_count; max burst = 2**CNT_W beats
//   TMO_W     8    width of the watchdog counter
//   TIMEOUT   255  idle ACTIVE cycles (no beat) before error; 0 disables watchdog
// PORTS
//   clk         in   1      clock, all state on rising edge
//   arst        in   1      reset; synchronous, active-high
//   i_restartn  in   1      synchronous clear, active-low; aborts burst, clears error
//   i_start     in   1      start request; sampled only in IDLE
//   i_len       in   CNT_W  beats-1 (AXI LEN encoding), sampled with i_start
//   i_beat      in   1      beat accepted this cycle (valid & ready)
//   o_busy      out  1      state == ACTIVE
//   o_last      out  1      current beat is final: ACTIVE & (o_count == len_q); combinational
//   o_count     out  CNT_W  beats accepted so far in current burst (registered)
//   o_done      out  1      one-cycle pulse, registered, the cycle after the final beat
//   o_timeout   out  1      level, high while state == ERROR
// BEHAVIOUR
//   Priority per edge: arst > ~i_restartn > FSM.
//   Reset/restart: state=IDLE, o_count=0, len_q=0, tmo=0, o_done=0, o_timeout=0.
//   FSM states: IDLE, ACTIVE, ERROR (2-bit encoding, unused code -> IDLE).
//   IDLE: i_start=1 -> len_q<=i_len, o_count<=0, tmo<=0, next ACTIVE.
//     i_beat in IDLE is ignored (no count, no error).
//   ACTIVE: i_start ignored; i_len not re-sampled.
//     i_beat & ~o_last -> o_count<=o_count+1, tmo<=0.
//     i_beat & o_last  -> next IDLE, o_count<=0, o_done<=1 (next cycle only).
//     ~i_beat -> tmo<=tmo+1 (saturating); if TIMEOUT!=0 and tmo==TIMEOUT-1
//       -> next ERROR. A beat in that cycle wins: no error.
//   ERROR: o_timeout=1, o_count held; leaves only via i_restartn=0 or arst.
//   o_done=0 in every cycle not immediately following a final beat.
//   Back-to-back: i_start may be asserted in the o_done cycle (state IDLE);
//     burst starts normally. Min burst period = len+2 cycles.
//   len=0: single-beat burst; o_last high in first ACTIVE cycle.
//   o_count never wraps: max value len_q <= 2**CNT_W-1, reset to 0 on completion.
//   Restart mid-burst: no o_done pulse, count lost, IDLE next cycle.
//   Simultaneous i_start and ~i_restartn: restart wins, start dropped.
// TESTING
//   1. reset; start len=3, beat every cycle -> o_last on 4th beat, o_done 1 cycle later, o_count 0.
//   2. start len=0, beat first ACTIVE cycle -> o_last=1 that cycle, o_done next, busy drops.
//   3. len=7, beats gapped with 3-cycle stalls, TIMEOUT=255 -> no error, done after 8th beat.
//   4. TIMEOUT=4, start, no beats -> ERROR after 4 idle ACTIVE cycles, o_timeout=1;
//      beats ignored; restartn=0 -> IDLE, o_timeout=0.
//   5. len=5, restartn=0 after 2 beats -> no o_done, o_count=0; new start len=1 completes.
//   6. start in o_done cycle of prior burst, CNT_W=8 len=255 -> 256 beats, o_count peaks 255.

Source files
------------

// File: rtl/ysyx_201979054_burst_tracker_if.sv
// Burst tracker bus bundle.
// Groups the control inputs (restart, start, length, beat) and the status
// outputs (busy, last, count, done, timeout) of the burst tracker.
//   master : the bus-master side driving start/len/beat and reading status
//   slave  : the tracker itself
interface ysyx_201979054_burst_tracker_if #(
  parameter int CNT_W = 8
);
  logic             i_restartn;
  logic             i_start;
  logic [CNT_W-1:0] i_len;
  logic             i_beat;
  logic             o_busy;
  logic             o_last;
  logic [CNT_W-1:0] o_count;
  logic             o_done;
  logic             o_timeout;

  modport master (
    output i_restartn, i_start, i_len, i_beat,
    input  o_busy, o_last, o_count, o_done, o_timeout
  );

  modport slave (
    input  i_restartn, i_start, i_len, i_beat,
    output o_busy, o_last, o_count, o_done, o_timeout
  );
endinterface

// File: rtl/ysyx_201979054_burst_tracker.sv
// Burst beat tracker.
// Latches a burst length (AXI LEN, beats-1) on start, counts accepted beats,
// flags the final beat, pulses done the cycle after it, and parks in an
// error state if an active burst sees no beat for TIMEOUT cycles.
// Ports:
//   clk  : clock
//   arst : synchronous active-high reset
//   bus  : slave modport of the tracker bundle (restart/start/len/beat in,
//          busy/last/count/done/timeout out)
//
// state  | meaning
// IDLE   | waiting for start; beats ignored
// ACTIVE | burst in progress, counting beats, watchdog running
// ERROR  | watchdog expired; held until restart or reset
module ysyx_201979054_burst_tracker #(
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic arst,
  ysyx_201979054_burst_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             done_q, done_d;

  logic last;
  logic tmo_hit;

  assign last    = (state_q == S_ACTIVE) && (cnt_q == len_q);
  // Watchdog fires on the cycle its counter would reach TIMEOUT.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    if (!bus.i_restartn) begin
      state_d = S_IDLE;
      len_d   = '0;
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            state_d = S_ACTIVE;
            len_d   = bus.i_len;
            cnt_d   = '0;
            tmo_d   = '0;
          end
        end
        S_ACTIVE: begin
          if (bus.i_beat) begin
            tmo_d = '0;
            if (last) begin
              state_d = S_IDLE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            if (tmo_q != '1) tmo_d = tmo_q + TMO_W'(1);
            if (tmo_hit) state_d = S_ERROR;
          end
        end
        S_ERROR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_busy    = (state_q == S_ACTIVE);
    bus.o_last    = last;
    bus.o_count   = cnt_q;
    bus.o_done    = done_q;
    bus.o_timeout = (state_q == S_ERROR);
  end

endmodule

// File: tb/tb_ysyx_201979054_burst_tracker.sv
// Bench for the burst tracker: two instances (watchdog 255 and 4) share
// identical stimulus; each is compared every cycle against its own
// transaction-level reference model.
module tb_ysyx_201979054_burst_tracker;
  logic clk;
  logic arst;
  int   checks;
  int   errors;

  ysyx_201979054_burst_tracker_if #(.CNT_W(8)) bus_a ();
  ysyx_201979054_burst_tracker_if #(.CNT_W(8)) bus_b ();

  ysyx_201979054_burst_tracker #(.CNT_W(8), .TMO_W(8), .TIMEOUT(255)) dut_a (
    .clk(clk), .arst(arst), .bus(bus_a)
  );
  ysyx_201979054_burst_tracker #(.CNT_W(8), .TMO_W(8), .TIMEOUT(4)) dut_b (
    .clk(clk), .arst(arst), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model, one slot per instance
  int tmo_lim [2] = '{255, 4};
  bit m_act  [2];
  bit m_err  [2];
  bit m_done [2];
  int m_len  [2];
  int m_cnt  [2];
  int m_stall[2];
  int peak_a;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int k);
    m_act[k] = 0; m_err[k] = 0; m_done[k] = 0;
    m_len[k] = 0; m_cnt[k] = 0; m_stall[k] = 0;
  endtask

  task automatic model_step(input int k, input bit rn, input bit st, input int ln, input bit bt);
    bit done_n;
    done_n = 0;
    if (!rn) begin
      model_clear(k);
      return;
    end
    if (m_err[k]) begin
      // parked, nothing changes
    end else if (m_act[k]) begin
      if (bt) begin
        m_stall[k] = 0;
        if (m_cnt[k] == m_len[k]) begin
          m_act[k] = 0;
          m_cnt[k] = 0;
          done_n   = 1;
        end else begin
          m_cnt[k]++;
        end
      end else begin
        m_stall[k]++;
        if (tmo_lim[k] != 0 && m_stall[k] == tmo_lim[k]) begin
          m_act[k] = 0;
          m_err[k] = 1;
        end
      end
    end else if (st) begin
      m_act[k]   = 1;
      m_len[k]   = ln;
      m_cnt[k]   = 0;
      m_stall[k] = 0;
    end
    m_done[k] = done_n;
  endtask

  task automatic compare_all();
    bit exp_last;
    exp_last = m_act[0] && (m_cnt[0] == m_len[0]);
    check_eq("a.busy",    32'(bus_a.o_busy),    32'(m_act[0]));
    check_eq("a.last",    32'(bus_a.o_last),    32'(exp_last));
    check_eq("a.count",   32'(bus_a.o_count),   32'(m_cnt[0]));
    check_eq("a.done",    32'(bus_a.o_done),    32'(m_done[0]));
    check_eq("a.timeout", 32'(bus_a.o_timeout), 32'(m_err[0]));
    exp_last = m_act[1] && (m_cnt[1] == m_len[1]);
    check_eq("b.busy",    32'(bus_b.o_busy),    32'(m_act[1]));
    check_eq("b.last",    32'(bus_b.o_last),    32'(exp_last));
    check_eq("b.count",   32'(bus_b.o_count),   32'(m_cnt[1]));
    check_eq("b.done",    32'(bus_b.o_done),    32'(m_done[1]));
    check_eq("b.timeout", 32'(bus_b.o_timeout), 32'(m_err[1]));
    if (32'(bus_a.o_count) > 32'(peak_a)) peak_a = int'(bus_a.o_count);
  endtask

  // One clock: drive inputs, advance at posedge, check at negedge.
  task automatic cycle(input bit rn, input bit st, input int ln, input bit bt);
    bus_a.i_restartn = rn; bus_a.i_start = st; bus_a.i_len = 8'(ln); bus_a.i_beat = bt;
    bus_b.i_restartn = rn; bus_b.i_start = st; bus_b.i_len = 8'(ln); bus_b.i_beat = bt;
    @(posedge clk);
    model_step(0, rn, st, ln, bt);
    model_step(1, rn, st, ln, bt);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    cycle(1, 0, 0, 0);
    model_clear(0); model_clear(1);
    cycle(1, 0, 0, 0);
    model_clear(0); model_clear(1);
    arst = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; peak_a = 0;
    arst = 1'b1;
    model_clear(0); model_clear(1);
    @(negedge clk);
    arst = 1'b1;
    bus_a.i_restartn = 1; bus_a.i_start = 0; bus_a.i_len = 0; bus_a.i_beat = 0;
    bus_b.i_restartn = 1; bus_b.i_start = 0; bus_b.i_len = 0; bus_b.i_beat = 0;
    @(posedge clk);
    @(negedge clk);
    compare_all();
    do_reset();

    // len=3, beat every cycle
    cycle(1, 1, 3, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
    check_eq("t1.done", 32'(bus_a.o_done), 32'd1);
    cycle(1, 0, 0, 0);

    // single-beat burst
    cycle(1, 1, 0, 0);
    check_eq("t2.last", 32'(bus_a.o_last), 32'd1);
    cycle(1, 0, 0, 1);
    check_eq("t2.busy", 32'(bus_a.o_busy), 32'd0);
    cycle(1, 0, 0, 0);

    // len=7 with 3-cycle stalls between beats
    cycle(1, 1, 7, 0);
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < 3; s++) cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 1);
    end
    check_eq("t3.done", 32'(bus_b.o_done), 32'd1);
    cycle(1, 0, 0, 0);

    // watchdog: no beats (instance b has TIMEOUT=4)
    cycle(1, 1, 2, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    check_eq("t4.timeout", 32'(bus_b.o_timeout), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1);
    cycle(0, 0, 0, 0);
    check_eq("t4.cleared", 32'(bus_b.o_timeout), 32'd0);

    // restart mid-burst, then a short burst
    cycle(1, 1, 5, 0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(0, 1, 3, 0);
    check_eq("t5.count", 32'(bus_a.o_count), 32'd0);
    cycle(1, 1, 1, 0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check_eq("t5.done", 32'(bus_a.o_done), 32'd1);

    // start in the done cycle, max-length burst
    peak_a = 0;
    cycle(1, 1, 255, 0);
    for (int i = 0; i < 256; i++) cycle(1, 0, 0, 1);
    check_eq("t6.peak", 32'(peak_a), 32'd255);
    check_eq("t6.done", 32'(bus_a.o_done), 32'd1);
    cycle(1, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rn, st, bt;
      int ln;
      rn = ($urandom_range(0, 49) != 0);
      st = ($urandom_range(0, 2) == 0);
      bt = ($urandom_range(0, 3) != 0);
      ln = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
      cycle(rn, st, ln, bt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
